// File: rtl/prewish_pkg.sv
// Shared types, mask table and default parameters for the prewish blinky controller.
package prewish_pkg;

  localparam int MASK_W               = 8;
  localparam int IDX_W                = 2;
  localparam int MASK_CNT             = 4;
  localparam int RST_CNT_W            = 8;
  localparam int NEWMASK_CLK_BITS_DEF = 26;
  localparam int RESET_CYCLES_DEF     = 16;

  typedef logic [MASK_W-1:0] mask_t;
  typedef logic [IDX_W-1:0]  mask_idx_t;

  localparam mask_t MASK_TABLE [MASK_CNT] = '{8'hA8, 8'hCA, 8'hF0, 8'h81};

  function automatic mask_t mask_lookup(input mask_idx_t idx);
    return MASK_TABLE[idx];
  endfunction

endpackage

// File: rtl/prewish_if.sv
// Mask-load bus between the mask loader (master) and the LED shifter (slave).
interface prewish_if;
  import prewish_pkg::*;

  logic  strobe;
  mask_t mask;
  logic  led;

  modport master (output strobe, output mask, input led);
  modport slave  (input strobe, input mask, output led);

endinterface

// File: rtl/prewish_blinky.sv
// LED shifter: loads an 8-bit mask on strobe and plays it MSB first,
// one bit every 2^BLINK_CLK_BITS cycles, rotating so the pattern repeats.
module prewish_blinky
  import prewish_pkg::*;
#(
  parameter int BLINK_CLK_BITS = NEWMASK_CLK_BITS_DEF - 3
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      srst_i,
  prewish_if.slave  bus
);

  localparam logic [BLINK_CLK_BITS-1:0] BCNT_MAX = {BLINK_CLK_BITS{1'b1}};
  localparam logic [BLINK_CLK_BITS-1:0] BCNT_ONE = BLINK_CLK_BITS'(1);

  mask_t                     shift_q, shift_d;
  logic [BLINK_CLK_BITS-1:0] bcnt_q, bcnt_d;
  logic                      led_q, led_d;
  logic                      bit_end_s;

  // A new strobe wins over a rotate that falls on the same cycle.
  always_comb begin
    bit_end_s = (bcnt_q == BCNT_MAX);
    shift_d   = shift_q;
    bcnt_d    = bcnt_q + BCNT_ONE;
    led_d     = shift_q[MASK_W-1];
    if (srst_i) begin
      shift_d = {MASK_W{1'b0}};
      bcnt_d  = {BLINK_CLK_BITS{1'b0}};
      led_d   = 1'b0;
    end else if (bus.strobe) begin
      shift_d = bus.mask;
      bcnt_d  = {BLINK_CLK_BITS{1'b0}};
    end else if (bit_end_s) begin
      shift_d = {shift_q[MASK_W-2:0], shift_q[MASK_W-1]};
    end else begin
      shift_d = shift_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= {MASK_W{1'b0}};
      bcnt_q  <= {BLINK_CLK_BITS{1'b0}};
      led_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      led_q   <= led_d;
    end
  end

  assign bus.led = led_q;

endmodule

// File: rtl/prewish_controller.sv
// Prewish blinky top: clock buffer, reset generator and periodic mask loader.
// Define PREWISH_LED_INVERT_EN for an active-low LED. All reset values are zero, so power-up matches a reset release.
module prewish_controller
  import prewish_pkg::*;
#(
  parameter int NEWMASK_CLK_BITS = NEWMASK_CLK_BITS_DEF,
  parameter int RESET_CYCLES     = RESET_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic CLK_O,
  output logic RST_O,
  output logic o_led
);

  localparam int BLINK_CLK_BITS = NEWMASK_CLK_BITS - 3;

  localparam logic [RST_CNT_W-1:0]        RST_TARGET = RST_CNT_W'(RESET_CYCLES);
  localparam logic [RST_CNT_W-1:0]        RST_ONE    = RST_CNT_W'(1);
  localparam logic [NEWMASK_CLK_BITS-1:0] NM_MAX     = {NEWMASK_CLK_BITS{1'b1}};
  localparam logic [NEWMASK_CLK_BITS-1:0] NM_ONE     = NEWMASK_CLK_BITS'(1);
  localparam mask_idx_t                   IDX_ONE    = IDX_W'(1);

  localparam logic [0:0] LD_FIRST = 1'b0;
  localparam logic [0:0] LD_RUN   = 1'b1;

  logic clk_s;
  logic srst_s;

  // Zero-delay stand-in for the SB_GB global buffer.
  assign clk_s = i_clk;
  assign CLK_O = clk_s;

  logic                 sync1_q, sync2_q;
  logic [RST_CNT_W-1:0] rcnt_q, rcnt_d;
  logic                 rst_done_q, rst_done_d;

  // Two-flop synchronizer on the reset release.
  always_ff @(posedge clk_s or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  // Release counter; done rises on the same edge the count reaches its target.
  always_comb begin
    rcnt_d = rcnt_q;
    if (!sync2_q) begin
      rcnt_d = {RST_CNT_W{1'b0}};
    end else if (rcnt_q != RST_TARGET) begin
      rcnt_d = rcnt_q + RST_ONE;
    end else begin
      rcnt_d = rcnt_q;
    end
    rst_done_d = (rcnt_d == RST_TARGET);
  end

  always_ff @(posedge clk_s or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcnt_q     <= {RST_CNT_W{1'b0}};
      rst_done_q <= 1'b0;
    end else begin
      rcnt_q     <= rcnt_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign srst_s = ~rst_done_q;
  assign RST_O  = srst_s;

  logic [0:0]                  ld_state_q, ld_state_d;
  mask_idx_t                   idx_q, idx_d;
  logic [NEWMASK_CLK_BITS-1:0] nm_cnt_q, nm_cnt_d;
  logic                        wrap_s;
  logic                        strobe_s;
  mask_t                       mask_s;

  // Loader: table[0] on the first free cycle, then the next entry on every counter wrap.
  always_comb begin
    ld_state_d = ld_state_q;
    idx_d      = idx_q;
    nm_cnt_d   = nm_cnt_q;
    strobe_s   = 1'b0;
    mask_s     = mask_lookup(idx_q);
    wrap_s     = (nm_cnt_q == NM_MAX);
    if (srst_s) begin
      ld_state_d = LD_FIRST;
      idx_d      = {IDX_W{1'b0}};
      nm_cnt_d   = {NEWMASK_CLK_BITS{1'b0}};
    end else begin
      case (ld_state_q)
        LD_FIRST: begin
          strobe_s   = 1'b1;
          mask_s     = mask_lookup({IDX_W{1'b0}});
          ld_state_d = LD_RUN;
          nm_cnt_d   = {NEWMASK_CLK_BITS{1'b0}};
        end
        LD_RUN: begin
          nm_cnt_d = nm_cnt_q + NM_ONE;
          if (wrap_s) begin
            idx_d    = idx_q + IDX_ONE;
            strobe_s = 1'b1;
            mask_s   = mask_lookup(idx_d);
          end else begin
            strobe_s = 1'b0;
          end
        end
        default: begin
          ld_state_d = LD_FIRST;
        end
      endcase
    end
  end

  always_ff @(posedge clk_s or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_state_q <= LD_FIRST;
      idx_q      <= {IDX_W{1'b0}};
      nm_cnt_q   <= {NEWMASK_CLK_BITS{1'b0}};
    end else begin
      ld_state_q <= ld_state_d;
      idx_q      <= idx_d;
      nm_cnt_q   <= nm_cnt_d;
    end
  end

  prewish_if blink_bus ();

  assign blink_bus.strobe = strobe_s;
  assign blink_bus.mask   = mask_s;

  prewish_blinky #(
    .BLINK_CLK_BITS (BLINK_CLK_BITS)
  ) u_blinky (
    .clk_i  (clk_s),
    .rst_ni (i_rst_n),
    .srst_i (srst_s),
    .bus    (blink_bus)
  );

`ifdef PREWISH_LED_INVERT_EN
  assign o_led = ~blink_bus.led;
`else
  assign o_led = blink_bus.led;
`endif

endmodule

// File: tb/tb_prewish_controller.sv
// Directed bench for prewish_controller: reset timing, mask playback and periodicity,
// mid-run reset and clock pass-through. Honours PREWISH_LED_INVERT_EN.
module tb_prewish_controller;

  localparam int NMB     = 7;
  localparam int RC      = 16;
  localparam int PERIOD  = 1 << NMB;
  localparam int BITLEN  = 1 << (NMB - 3);
  localparam int LOAD0   = RC + 3;
  localparam int RST_AT  = 680;

`ifdef PREWISH_LED_INVERT_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  logic CLK_O;
  logic RST_O;
  logic o_led;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  time t_clk_r  = 0;
  time t_clko_r = 0;

  logic [7:0] exp_masks [4] = '{8'hA8, 8'hCA, 8'hF0, 8'h81};

  prewish_if mon ();
  assign mon.led    = o_led;
  assign mon.strobe = 1'b0;
  assign mon.mask   = 8'h00;

  prewish_controller #(
    .NEWMASK_CLK_BITS (NMB),
    .RESET_CYCLES     (RC)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .CLK_O   (CLK_O),
    .RST_O   (RST_O),
    .o_led   (o_led)
  );

  always #1 i_clk = ~i_clk;

  always @(posedge i_clk) t_clk_r = $time;
  always @(posedge CLK_O) t_clko_r = $time;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: wait for the falling edge after the next rising edge.
  task automatic tick();
    @(negedge i_clk);
    cyc++;
    check("clk_o_edge", 32'(t_clko_r), 32'(t_clk_r));
  endtask

  task automatic goto(input int e);
    while (cyc < e) tick();
  endtask

  task automatic check_mask(input int load_e, input logic [7:0] m);
    logic [7:0] mm;
    mm = m;
    for (int k = 0; k < 8; k++) begin
      goto(load_e + 1 + BITLEN * k);
      check("led_bit_first", 32'(o_led), 32'(mm[7-k] ^ LED_INV));
      goto(load_e + BITLEN * (k + 1));
      check("led_bit_last", 32'(o_led), 32'(mm[7-k] ^ LED_INV));
      check("rst_low", 32'(RST_O), 32'd0);
    end
  endtask

  initial begin
    for (int e = 1; e < RC + 2; e++) begin
      tick();
      check("rst_hold", 32'(RST_O), 32'd1);
      check("led_in_rst", 32'(o_led), 32'(LED_INV));
    end
    tick();
    check("rst_fall", 32'(RST_O), 32'd0);
    check("led_after_rst", 32'(o_led), 32'(LED_INV));
    goto(LOAD0);
    check("led_at_load0", 32'(o_led), 32'(LED_INV));

    for (int n = 0; n < 5; n++) begin
      check_mask(LOAD0 + PERIOD * n, exp_masks[n % 4]);
    end

    goto(RST_AT);
    check("led_before_rst", 32'(o_led), 32'(1'b1 ^ LED_INV));
    i_rst_n = 1'b0;
    tick();
    check("rst_async_rise", 32'(RST_O), 32'd1);
    check("led_async_off", 32'(o_led), 32'(LED_INV));
    tick();
    tick();
    i_rst_n = 1'b1;
    while (cyc < RST_AT + 3 + RC + 1) begin
      tick();
      check("rst_rehold", 32'(RST_O), 32'd1);
      check("led_rehold", 32'(o_led), 32'(LED_INV));
    end
    tick();
    check("rst_refall", 32'(RST_O), 32'd0);
    check("led_refall", 32'(o_led), 32'(LED_INV));
    check_mask(RST_AT + 3 + RC + 3, exp_masks[0]);
    check_mask(RST_AT + 3 + RC + 3 + PERIOD, exp_masks[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
